// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 access encodings,
// peripheral base addresses, the address-region selector and helper functions
// for page decode and byte-lane merging.
package lsu_pkg;

  // Access type, RISC-V funct3 encoding
  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  // Peripheral base addresses (each decodes one word in its 4 KiB page)
  localparam logic [31:0] LEDR_BASE  = 32'h1000_0000;
  localparam logic [31:0] LEDG_BASE  = 32'h1000_1000;
  localparam logic [31:0] HEXLO_BASE = 32'h1000_2000;
  localparam logic [31:0] HEXHI_BASE = 32'h1000_3000;
  localparam logic [31:0] LCD_BASE   = 32'h1000_4000;
  localparam logic [31:0] SW_BASE    = 32'h1001_0000;
  localparam logic [31:0] BTN_BASE   = 32'h1001_1000;

  typedef enum logic [3:0] {
    SEL_NONE  = 4'd0,
    SEL_DMEM  = 4'd1,
    SEL_LEDR  = 4'd2,
    SEL_LEDG  = 4'd3,
    SEL_HEXLO = 4'd4,
    SEL_HEXHI = 4'd5,
    SEL_LCD   = 4'd6,
    SEL_SW    = 4'd7,
    SEL_BTN   = 4'd8
  } sel_e;

  // True when addr hits word 0 of the 4 KiB page that starts at base
  function automatic logic page_hit(input logic [31:0] addr, input logic [31:0] base);
    return (addr[31:12] == base[31:12]) && (addr[11:2] == 10'd0);
  endfunction

  // Replace the byte lanes of old_v selected by be with those of new_v
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
      else       res[8*i +: 8] = old_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Data memory: WORDS x 32-bit, byte-enable synchronous write, asynchronous
// word read. Contents are deliberately not reset.
// Ports: i_clk clock, i_we write strobe, i_be byte enables, i_addr word
// index, i_wdata lane-replicated write data, o_rdata word at i_addr.
module dmem
  import lsu_pkg::*;
#(
  parameter int WORDS = 512,
  parameter int AW    = 9
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem_r [WORDS];

  // Byte-lane write on the rising edge
  always_ff @(posedge i_clk) begin
    if (i_we) mem_r[i_addr] <= merge_bytes(mem_r[i_addr], i_wdata, i_be);
  end

  assign o_rdata = mem_r[i_addr];

endmodule

// File: rtl/lsu.sv
// Load/store unit: address decode, lane steering, load extension, memory-mapped
// LED/HEX/LCD output registers and synchronized switch/button inputs.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_lsu_addr,
// i_st_data, i_lsu_wren, i_lsu_op describe the access; o_ld_data is the
// combinational load result; o_io_* are the registered peripheral outputs;
// i_io_sw/i_io_btn are asynchronous board inputs.
module lsu
  import lsu_pkg::*;
#(
  parameter int DMEM_WORDS = 512
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_lsu_op,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] o_io_lcd,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn
);

  localparam int          AW         = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam logic [31:0] DMEM_LIMIT = 32'(DMEM_WORDS);

  sel_e        sel_s;
  logic        ok_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic        we_s;
  logic [31:0] dmem_rdata_s;
  logic [31:0] rword_s;
  logic [31:0] shifted_s;
  logic [31:0] load_s;

  logic [31:0] ledr_r, ledg_r, hexlo_r, hexhi_r, lcd_r;
  logic [31:0] sw_meta_r, sw_sync_r;
  logic [3:0]  btn_meta_r, btn_sync_r;

  // Region decode from the byte address
  always_comb begin
    sel_s = SEL_NONE;
    if ({2'b00, i_lsu_addr[31:2]} < DMEM_LIMIT) sel_s = SEL_DMEM;
    else if (page_hit(i_lsu_addr, LEDR_BASE))  sel_s = SEL_LEDR;
    else if (page_hit(i_lsu_addr, LEDG_BASE))  sel_s = SEL_LEDG;
    else if (page_hit(i_lsu_addr, HEXLO_BASE)) sel_s = SEL_HEXLO;
    else if (page_hit(i_lsu_addr, HEXHI_BASE)) sel_s = SEL_HEXHI;
    else if (page_hit(i_lsu_addr, LCD_BASE))   sel_s = SEL_LCD;
    else if (page_hit(i_lsu_addr, SW_BASE))    sel_s = SEL_SW;
    else if (page_hit(i_lsu_addr, BTN_BASE))   sel_s = SEL_BTN;
    else                                       sel_s = SEL_NONE;
  end

  // Alignment check, byte enables and lane-replicated store data per access size
  always_comb begin
    ok_s    = 1'b0;
    be_s    = 4'b0000;
    wdata_s = 32'd0;
    case (i_lsu_op)
      OP_B, OP_BU: begin
        ok_s    = 1'b1;
        be_s    = 4'b0001 << i_lsu_addr[1:0];
        wdata_s = {4{i_st_data[7:0]}};
      end
      OP_H, OP_HU: begin
        ok_s    = ~i_lsu_addr[0];
        be_s    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{i_st_data[15:0]}};
      end
      OP_W: begin
        ok_s    = (i_lsu_addr[1:0] == 2'b00);
        be_s    = 4'b1111;
        wdata_s = i_st_data;
      end
      default: begin
        ok_s    = 1'b0;
        be_s    = 4'b0000;
        wdata_s = 32'd0;
      end
    endcase
  end

  // Gating with i_rst_n keeps a store issued during reset out of the (unreset) DMEM
  assign we_s = i_lsu_wren & i_rst_n & ok_s;

  dmem #(.WORDS(DMEM_WORDS), .AW(AW)) u_dmem (
    .i_clk   (i_clk),
    .i_we    (we_s && (sel_s == SEL_DMEM)),
    .i_be    (be_s),
    .i_addr  (i_lsu_addr[AW+1:2]),
    .i_wdata (wdata_s),
    .o_rdata (dmem_rdata_s)
  );

  // Peripheral registers and two-flop input synchronizers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ledr_r     <= 32'd0;
      ledg_r     <= 32'd0;
      hexlo_r    <= 32'd0;
      hexhi_r    <= 32'd0;
      lcd_r      <= 32'd0;
      sw_meta_r  <= 32'd0;
      sw_sync_r  <= 32'd0;
      btn_meta_r <= 4'd0;
      btn_sync_r <= 4'd0;
    end else begin
      sw_meta_r  <= i_io_sw;
      sw_sync_r  <= sw_meta_r;
      btn_meta_r <= i_io_btn;
      btn_sync_r <= btn_meta_r;
      if (we_s) begin
        case (sel_s)
          SEL_LEDR:  ledr_r  <= merge_bytes(ledr_r,  wdata_s, be_s);
          SEL_LEDG:  ledg_r  <= merge_bytes(ledg_r,  wdata_s, be_s);
          SEL_HEXLO: hexlo_r <= merge_bytes(hexlo_r, wdata_s, be_s);
          SEL_HEXHI: hexhi_r <= merge_bytes(hexhi_r, wdata_s, be_s);
          SEL_LCD:   lcd_r   <= merge_bytes(lcd_r,   wdata_s, be_s);
          default:   ledr_r  <= ledr_r;
        endcase
      end
    end
  end

  // Word read mux; unmapped regions read as zero
  always_comb begin
    rword_s = 32'd0;
    case (sel_s)
      SEL_DMEM:  rword_s = dmem_rdata_s;
      SEL_LEDR:  rword_s = ledr_r;
      SEL_LEDG:  rword_s = ledg_r;
      SEL_HEXLO: rword_s = hexlo_r;
      SEL_HEXHI: rword_s = hexhi_r;
      SEL_LCD:   rword_s = lcd_r;
      SEL_SW:    rword_s = sw_sync_r;
      SEL_BTN:   rword_s = {28'd0, btn_sync_r};
      default:   rword_s = 32'd0;
    endcase
  end

  assign shifted_s = rword_s >> {i_lsu_addr[1:0], 3'b000};

  // Lane extraction and sign/zero extension
  always_comb begin
    load_s = 32'd0;
    case (i_lsu_op)
      OP_B:    load_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
      OP_BU:   load_s = {24'd0, shifted_s[7:0]};
      OP_H:    load_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
      OP_HU:   load_s = {16'd0, shifted_s[15:0]};
      OP_W:    load_s = rword_s;
      default: load_s = 32'd0;
    endcase
  end

  assign o_ld_data = (ok_s && i_rst_n) ? load_s : 32'd0;

  assign o_io_ledr = ledr_r;
  assign o_io_ledg = ledg_r;
  assign o_io_lcd  = lcd_r;
  assign o_io_hex0 = hexlo_r[6:0];
  assign o_io_hex1 = hexlo_r[14:8];
  assign o_io_hex2 = hexlo_r[22:16];
  assign o_io_hex3 = hexlo_r[30:24];
  assign o_io_hex4 = hexhi_r[6:0];
  assign o_io_hex5 = hexhi_r[14:8];
  assign o_io_hex6 = hexhi_r[22:16];
  assign o_io_hex7 = hexhi_r[30:24];

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with hand-computed expected values.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic        wren;
  logic [2:0]  op;
  logic [31:0] ld_data;
  logic [31:0] ledr, ledg, lcd;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [31:0] sw;
  logic [3:0]  btn;

  int n_cmp = 0;
  int n_err = 0;

  lsu #(.DMEM_WORDS(512)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_lsu_addr (addr),
    .i_st_data  (st_data),
    .i_lsu_wren (wren),
    .i_lsu_op   (op),
    .o_ld_data  (ld_data),
    .o_io_ledr  (ledr),
    .o_io_ledg  (ledg),
    .o_io_hex0  (hex0),
    .o_io_hex1  (hex1),
    .o_io_hex2  (hex2),
    .o_io_hex3  (hex3),
    .o_io_hex4  (hex4),
    .o_io_hex5  (hex5),
    .o_io_hex6  (hex6),
    .o_io_hex7  (hex7),
    .o_io_lcd   (lcd),
    .i_io_sw    (sw),
    .i_io_btn   (btn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one store across a rising edge, return 1 time unit after it
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] o);
    addr = a; st_data = d; op = o; wren = 1'b1;
    @(posedge clk);
    #1;
    wren = 1'b0;
  endtask

  // Present a load and compare the combinational result
  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] o,
                         input logic [31:0] exp);
    addr = a; op = o; wren = 1'b0;
    #1;
    check_eq(tag, ld_data, exp);
  endtask

  initial begin
    rst_n = 1'b1; addr = 32'd0; st_data = 32'd0; wren = 1'b0; op = 3'b010;
    sw = 32'd0; btn = 4'd0;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_ledr", ledr, 32'd0);
    check_eq("rst_ledg", ledg, 32'd0);
    check_eq("rst_lcd", lcd, 32'd0);
    check_eq("rst_hex0", {25'd0, hex0}, 32'd0);
    check_eq("rst_hex7", {25'd0, hex7}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_load("rst_sw_read", 32'h1001_0000, 3'b010, 32'd0);

    // Word round trip and extension
    do_store(32'h0000_0010, 32'hDEAD_BEEF, 3'b010);
    do_load("lw_10", 32'h0000_0010, 3'b010, 32'hDEAD_BEEF);
    do_load("lb_13", 32'h0000_0013, 3'b000, 32'hFFFF_FFDE);
    do_load("lbu_13", 32'h0000_0013, 3'b100, 32'h0000_00DE);
    do_load("lh_12", 32'h0000_0012, 3'b001, 32'hFFFF_DEAD);
    do_load("lhu_10", 32'h0000_0010, 3'b101, 32'h0000_BEEF);

    // Lane writes and misalignment
    do_store(32'h0000_0012, 32'h0000_1234, 3'b001);
    do_load("sh_12", 32'h0000_0010, 3'b010, 32'h1234_BEEF);
    do_store(32'h0000_0011, 32'h0000_FFFF, 3'b001);
    do_load("sh_mis", 32'h0000_0010, 3'b010, 32'h1234_BEEF);
    do_load("lh_mis", 32'h0000_0011, 3'b001, 32'd0);
    do_load("lw_mis", 32'h0000_0012, 3'b010, 32'd0);
    do_store(32'h0000_0010, 32'h0000_00AB, 3'b000);
    do_load("sb_10", 32'h0000_0010, 3'b010, 32'h1234_BEAB);

    // HEX packing
    do_store(32'h1000_2000, 32'h4079_2430, 3'b010);
    check_eq("hex0", {25'd0, hex0}, 32'h30);
    check_eq("hex1", {25'd0, hex1}, 32'h24);
    check_eq("hex2", {25'd0, hex2}, 32'h79);
    check_eq("hex3", {25'd0, hex3}, 32'h40);
    do_store(32'h1000_2001, 32'h0000_007F, 3'b000);
    check_eq("hex1_sb", {25'd0, hex1}, 32'h7F);
    check_eq("hex0_keep", {25'd0, hex0}, 32'h30);
    check_eq("hex2_keep", {25'd0, hex2}, 32'h79);
    do_load("lw_hexlo", 32'h1000_2000, 3'b010, 32'h4079_7F30);
    do_store(32'h1000_3000, 32'h0102_0304, 3'b010);
    check_eq("hex4", {25'd0, hex4}, 32'h04);
    check_eq("hex7", {25'd0, hex7}, 32'h01);

    // Other output registers
    do_store(32'h1000_0000, 32'hFFFF_FFFF, 3'b010);
    check_eq("ledr", ledr, 32'hFFFF_FFFF);
    do_store(32'h1000_1002, 32'h0000_5A5A, 3'b001);
    check_eq("ledg_sh", ledg, 32'h5A5A_0000);
    do_store(32'h1000_4000, 32'h1234_5678, 3'b010);
    check_eq("lcd", lcd, 32'h1234_5678);
    do_load("lw_lcd", 32'h1000_4000, 3'b010, 32'h1234_5678);
    do_store(32'h1000_0004, 32'h0000_0000, 3'b010);
    check_eq("ledr_wrongword", ledr, 32'hFFFF_FFFF);
    do_load("lw_wrongword", 32'h1000_0004, 3'b010, 32'd0);

    // Switch / button synchronizers (we are 1 unit after a rising edge)
    sw = 32'h0000_A5A5;
    btn = 4'hA;
    @(posedge clk); #1;
    do_load("sw_1edge", 32'h1001_0000, 3'b010, 32'd0);
    @(posedge clk); #1;
    do_load("sw_2edge", 32'h1001_0000, 3'b010, 32'h0000_A5A5);
    do_load("btn_2edge", 32'h1001_1000, 3'b010, 32'h0000_000A);
    do_store(32'h1001_0000, 32'hFFFF_FFFF, 3'b010);
    do_load("sw_ro", 32'h1001_0000, 3'b010, 32'h0000_A5A5);

    // Unmapped, illegal op, load/store race
    do_store(32'h0000_0000, 32'h1122_3344, 3'b010);
    do_load("lw_unmapped", 32'h2000_0000, 3'b010, 32'd0);
    do_store(32'h0000_0800, 32'hCAFE_F00D, 3'b010);
    do_load("unmapped_st", 32'h0000_0000, 3'b010, 32'h1122_3344);
    check_eq("unmapped_ledr", ledr, 32'hFFFF_FFFF);
    do_store(32'h0000_0000, 32'hFFFF_FFFF, 3'b011);
    do_load("badop_st", 32'h0000_0000, 3'b010, 32'h1122_3344);
    do_load("badop_ld", 32'h0000_0000, 3'b111, 32'd0);
    addr = 32'h0000_0000; op = 3'b010; st_data = 32'h5566_7788; wren = 1'b1;
    #1;
    check_eq("race_old", ld_data, 32'h1122_3344);
    @(posedge clk); #1;
    wren = 1'b0;
    #1;
    check_eq("race_new", ld_data, 32'h5566_7788);

    // Reset asserted mid-store
    do_store(32'h0000_0004, 32'h0BAD_F00D, 3'b010);
    addr = 32'h0000_0004; st_data = 32'hFFFF_FFFF; op = 3'b010; wren = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_ledr", ledr, 32'd0);
    check_eq("rstmid_ledg", ledg, 32'd0);
    check_eq("rstmid_hex1", {25'd0, hex1}, 32'd0);
    check_eq("rstmid_lcd", lcd, 32'd0);
    @(posedge clk); #1;
    wren = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_load("rst_blocked", 32'h0000_0004, 3'b010, 32'h0BAD_F00D);
    do_store(32'h1000_0000, 32'h0000_0001, 3'b010);
    check_eq("resume_ledr", ledr, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter: DMEM_WORDS, default 512, data-memory depth in 32-bit words (2 KiB).
REQ-002 SHALL have port: i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_lsu_addr  input  32  byte address, driven by ALU result.
REQ-005 SHALL have port: i_st_data  input  32  store data (rs2).
REQ-006 SHALL have port: i_lsu_wren  input  1  store enable for the current instruction.
REQ-007 SHALL have port: i_lsu_op  input  3  access type, RISC-V funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port: o_ld_data  output  32  load result, extended to 32 bits.
REQ-009 SHALL have ports: o_io_ledr  output  32 and o_io_ledg  output  32  LED registers.
REQ-010 SHALL have ports: o_io_hex0..o_io_hex7  output  7 each  seven-segment digits.
REQ-011 SHALL have port: o_io_lcd  output  32  LCD control register.
REQ-012 SHALL have ports: i_io_sw  input  32 and i_io_btn  input  4  asynchronous board inputs.

Function
REQ-013 Address map: 0x0000_0000-0x0000_07FF DMEM; 0x1000_0000 LEDR; 0x1000_1000 LEDG; 0x1000_2000 HEX0-3; 0x1000_3000 HEX4-7; 0x1000_4000 LCD; 0x1001_0000 SW (read-only); 0x1001_1000 BTN (read-only). Each peripheral decodes one 32-bit word (addr[11:2] == 0 within its 4 KiB page).
REQ-014 Loads are combinational: o_ld_data reflects current state and address in the same cycle.
REQ-015 Stores commit on the rising edge when i_lsu_wren=1; new data is visible to loads from the next cycle.
REQ-016 Byte lane = addr[1:0]. SB writes one lane. SH writes lanes {addr[1],0} and {addr[1],1}. SW writes all four lanes. Unwritten lanes are unchanged.
REQ-017 Misaligned access is ignored: SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]!=0. A store does not write; a load returns 0.
REQ-018 Loads: LB/LH sign-extend and LBU/LHU zero-extend the selected lane(s); LW returns the whole word.
REQ-019 Unmapped address: load returns 0; store is discarded.
REQ-020 Stores to SW/BTN pages are discarded. Loads from output registers return their current contents.
REQ-021 HEX word packing: digit n (n mod 4) occupies bits [8k+6:8k] with k = n mod 4; bit 8k+7 is stored but unused.
REQ-022 i_io_sw and i_io_btn pass through a two-flop synchronizer. A load returns the synchronized value, so an input change becomes visible on the 2nd rising edge after it. BTN reads are zero-extended to 32 bits.
REQ-023 i_lsu_op values 011, 110, 111: load returns 0; store is discarded.
REQ-024 Simultaneous load and store to the same address in one cycle: o_ld_data returns the old (pre-edge) data.

Reset
REQ-025 On i_rst_n=0, asynchronously clear LEDR, LEDG, HEX and LCD registers and both synchronizer stages to 0. All outputs then read 0.
REQ-026 DMEM contents are not reset. Stores are blocked while i_rst_n=0.
REQ-027 Reset asserted mid-store: the store does not occur and outputs read 0 immediately. Operation resumes on the first edge after deassertion.

Structure
REQ-028 The shared constants file SHALL hold the LSU op encodings and every peripheral base address. None are hard-coded in lsu.
REQ-029 DMEM SHALL be a sub-module, dmem, with a byte-enable synchronous write and an asynchronous word read. lsu holds decode, lane steering, extension, the peripheral registers and the synchronizers.

Verification
REQ-030 Word round trip: SW 0xDEADBEEF to 0x0000_0010, then LW 0x0000_0010 -> 0xDEADBEEF. LB 0x0000_0013 -> 0xFFFFFFDE; LBU 0x0000_0013 -> 0x000000DE.
REQ-031 Lane writes: SH 0x1234 to 0x0000_0012 over 0xDEADBEEF -> LW returns 0x1234BEEF. Misaligned SH to 0x0000_0011 -> word unchanged; LH 0x0000_0011 -> 0.
REQ-032 HEX store: SW 0x40792430 to 0x1000_2000 -> hex0=0x30, hex1=0x24, hex2=0x79, hex3=0x40. SB 0x7F to 0x1000_2001 -> only hex1=0x7F.
REQ-033 Switch sync: i_io_sw 0 -> 0x0000A5A5 -> LW 0x1001_0000 reads 0 after 1 edge and 0x0000A5A5 after 2 edges. SW to 0x1001_0000 has no effect.
REQ-034 Reset: LEDR=0xFFFFFFFF, then i_rst_n low between edges -> o_io_ledr=0 immediately. A store with i_lsu_wren=1 during reset is not performed.
REQ-035 Unmapped: LW 0x2000_0000 -> 0. SW to 0x0000_0800 leaves DMEM word 0 and all outputs unchanged.
